// File: rtl/universal_reg_pkg.sv
// Purpose: shared opcode encoding for the universal register bank.
// Latency: n/a (constants only).
// Backpressure: n/a.
package universal_reg_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_HOLD = 3'b000;
    localparam logic [OP_W-1:0] OP_LOAD = 3'b001;
    localparam logic [OP_W-1:0] OP_CLR  = 3'b010;
    localparam logic [OP_W-1:0] OP_SHL  = 3'b011;
    localparam logic [OP_W-1:0] OP_SHR  = 3'b100;
    localparam logic [OP_W-1:0] OP_INC  = 3'b101;
    localparam logic [OP_W-1:0] OP_DEC  = 3'b110;
    localparam logic [OP_W-1:0] OP_INCS = 3'b111;

endpackage

// File: rtl/universal_reg_bank_if.sv
// Purpose: bundles the per-channel opcode/data inputs and status outputs of the register bank.
// Latency: n/a (wiring only).
// Backpressure: none; master presents an op every cycle, slave consumes it every cycle.
// Signals: op/d/ser_in/ovf_clr driven by master; q/ser_out/ovf/zero driven by slave.
interface universal_reg_bank_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    import universal_reg_pkg::*;

    logic [OP_W*CHANNELS-1:0]  op;
    logic [WIDTH*CHANNELS-1:0] d;
    logic [CHANNELS-1:0]       ser_in;
    logic [CHANNELS-1:0]       ovf_clr;
    logic [WIDTH*CHANNELS-1:0] q;
    logic [CHANNELS-1:0]       ser_out;
    logic [CHANNELS-1:0]       ovf;
    logic [CHANNELS-1:0]       zero;

    modport master (
        output op, d, ser_in, ovf_clr,
        input  q, ser_out, ovf, zero
    );

    modport slave (
        input  op, d, ser_in, ovf_clr,
        output q, ser_out, ovf, zero
    );

endinterface

// File: rtl/universal_reg_chan.sv
// Purpose: one WIDTH-bit register with hold/load/clear/shift/count ops and sticky ovf, zero status.
// Latency: 1 cycle from op/d/ser_in/ovf_clr to q/ser_out/ovf/zero; async reset acts immediately.
// Backpressure: none; an op is consumed every cycle.
// Ports: clk, reset (async, active high), op, d, ser_in, ovf_clr in; q, ser_out, ovf, zero out.
module universal_reg_chan
    import universal_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             ovf,
    output logic             zero
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [WIDTH-1:0] q_nxt;
    logic             ser_out_nxt;
    logic             ovf_set;
    logic             ovf_nxt;
    logic             zero_nxt;

    always_comb begin
        q_nxt       = q;
        ser_out_nxt = ser_out;
        ovf_set     = 1'b0;
        case (op)
            OP_HOLD: q_nxt = q;
            OP_LOAD: q_nxt = d;
            OP_CLR:  q_nxt = '0;
            OP_SHL: begin
                q_nxt       = {q[WIDTH-2:0], ser_in};
                ser_out_nxt = q[WIDTH-1];
            end
            OP_SHR: begin
                q_nxt       = {ser_in, q[WIDTH-1:1]};
                ser_out_nxt = q[0];
            end
            OP_INC: begin
                q_nxt   = q + ONE;
                ovf_set = (q == ALL_ONES);
            end
            OP_DEC: begin
                q_nxt   = q - ONE;
                ovf_set = (q == '0);
            end
            OP_INCS: begin
                // Saturate: stay at all-ones and flag the attempted overflow.
                if (q == ALL_ONES) begin
                    q_nxt   = q;
                    ovf_set = 1'b1;
                end else begin
                    q_nxt = q + ONE;
                end
            end
            default: q_nxt = q;
        endcase
    end

    // A set event in the same cycle as ovf_clr must win.
    assign ovf_nxt  = ovf_set | (ovf & ~ovf_clr);
    // zero tracks the value being written, so it is never a cycle behind q.
    assign zero_nxt = (q_nxt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q       <= RESET_VAL;
            ser_out <= 1'b0;
            ovf     <= 1'b0;
            zero    <= (RESET_VAL == '0);
        end else begin
            q       <= q_nxt;
            ser_out <= ser_out_nxt;
            ovf     <= ovf_nxt;
            zero    <= zero_nxt;
        end
    end

endmodule

// File: rtl/universal_reg_bank.sv
// Purpose: CHANNELS independent universal registers; this level only slices the shared buses.
// Latency: 1 cycle from any channel input to its outputs; async reset acts immediately.
// Backpressure: none; every channel consumes its op every cycle.
// Ports: clk, reset (async, active high), bus (slave modport carrying op/d/ser_in/ovf_clr and q/ser_out/ovf/zero).
module universal_reg_bank
    import universal_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               CHANNELS  = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic                 clk,
    input logic                 reset,
    universal_reg_bank_if.slave bus
);

    logic [CHANNELS-1:0][WIDTH-1:0] q_arr;
    logic [CHANNELS-1:0]            ser_out_arr;
    logic [CHANNELS-1:0]            ovf_arr;
    logic [CHANNELS-1:0]            zero_arr;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        universal_reg_chan #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .op      (bus.op[OP_W*i +: OP_W]),
            .d       (bus.d[WIDTH*i +: WIDTH]),
            .ser_in  (bus.ser_in[i]),
            .ovf_clr (bus.ovf_clr[i]),
            .q       (q_arr[i]),
            .ser_out (ser_out_arr[i]),
            .ovf     (ovf_arr[i]),
            .zero    (zero_arr[i])
        );
    end

    assign bus.q       = q_arr;
    assign bus.ser_out = ser_out_arr;
    assign bus.ovf     = ovf_arr;
    assign bus.zero    = zero_arr;

endmodule
